// File: rtl/dot_product_pkg.sv
// rtl/dot_product_pkg.sv - shared sizing constants and state encoding for the dot-product engine
package dot_product_pkg;

    // Default sizing, shared with MEMController
    localparam int Nums_Data_in_bits       = 4;
    localparam int Nums_Data               = 1 << Nums_Data_in_bits;
    localparam int Nums_Pipeline_Stages    = 4;
    localparam int Pipeline_Tail           = Nums_Pipeline_Stages - 1;
    localparam int Total_Computation_Steps = Nums_Data + Pipeline_Tail;
    localparam int Step_Width              = Nums_Data_in_bits + 1;

    // Run-level FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_INIT = 3'd1;
    localparam state_t S_LOAD = 3'd2;
    localparam state_t S_CRST = 3'd3;
    localparam state_t S_COMP = 3'd4;
    localparam state_t S_DONE = 3'd5;

endpackage

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - run-level FSM sequencing MEMController phases for one dot product
module dot_product_sequencer
    import dot_product_pkg::*;
#(
    parameter int Data_Bits     = Nums_Data_in_bits,
    parameter int Pipe_Stages   = Nums_Pipeline_Stages
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  load_valid,
    output logic                  Mem_reset,
    output logic                  Mem_Index_reset,
    output logic                  Comp_reset,
    output logic                  load_from_file,
    output logic                  Computing,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [Data_Bits:0]    Step_Count
);

    localparam int CW         = Data_Bits + 1;
    localparam int LOAD_BEATS = 1 << Data_Bits;
    localparam int COMP_STEPS = LOAD_BEATS + Pipe_Stages - 1;

    // Terminal counter values: the beat/step that ends each counted phase
    localparam logic [CW-1:0] LAST_LOAD = CW'(LOAD_BEATS - 1);
    localparam logic [CW-1:0] LAST_COMP = CW'(COMP_STEPS - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_t          state;
    logic [CW-1:0]   count;
    logic            aborted_q;

    // State register, step counter and abort flag; abort outranks every transition outside IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            count     <= '0;
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state     <= S_IDLE;
                count     <= '0;
                aborted_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        count <= '0;
                        if (start && !abort) begin
                            state <= S_INIT;
                        end
                    end
                    S_INIT: begin
                        count <= '0;
                        state <= S_LOAD;
                    end
                    S_LOAD: begin
                        // Only beats the operand source actually offers are counted
                        if (load_valid) begin
                            count <= count + ONE;
                            if (count == LAST_LOAD) begin
                                state <= S_CRST;
                            end
                        end
                    end
                    S_CRST: begin
                        count <= '0;
                        state <= S_COMP;
                    end
                    S_COMP: begin
                        count <= count + ONE;
                        if (count == LAST_COMP) begin
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        count <= '0;
                        state <= S_IDLE;
                    end
                    default: begin
                        count <= '0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Moore decode of the state register; load_from_file additionally gated by load_valid
    always_comb begin
        Mem_reset       = 1'b0;
        Mem_Index_reset = 1'b0;
        Comp_reset      = 1'b0;
        load_from_file  = 1'b0;
        Computing       = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        aborted         = aborted_q;
        Step_Count      = '0;
        case (state)
            S_INIT: begin
                Mem_reset       = 1'b1;
                Mem_Index_reset = 1'b1;
                Comp_reset      = 1'b1;
                busy            = 1'b1;
            end
            S_LOAD: begin
                load_from_file  = load_valid;
                busy            = 1'b1;
                Step_Count      = count;
            end
            S_CRST: begin
                Comp_reset      = 1'b1;
                busy            = 1'b1;
            end
            S_COMP: begin
                Computing       = 1'b1;
                busy            = 1'b1;
                Step_Count      = count;
            end
            S_DONE: begin
                done            = 1'b1;
                busy            = 1'b1;
            end
            default: begin
                busy            = 1'b0;
            end
        endcase
    end

endmodule
